ysyx_22051468_decode_stage: RTL and testbench
=============================================

Name: ysyx_22051468_decode_stage

Overview:
Registered RV64 decode stage between IF and EX, with a valid/ready handshake. Accepts a 32-bit instruction and its PC, and decodes the op class, register indices, sign-extended immediate, qualifier flags and the one-hot ALU type. The result goes into a small output FIFO so IF is not stalled by single-cycle EX back-pressure. Adds W-ops, the M extension, immediate generation, an illegal-instruction flag, flush and buffering.

Parameters:
XLEN, 64, datapath/immediate width
PC_W, 64, PC width
TYPE_W, 16, one-hot explicit-type width; must be >= 16
BUF_DEPTH, 2, output FIFO entries (power of two, >= 1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush_i  in  1  discard all buffered entries and the current input beat
in_valid_i  in  1  IF beat valid
in_ready_o  out  1  stage can accept a beat
inst_i  in  32  raw instruction
pc_i  in  PC_W  instruction PC
out_valid_o  out  1  decoded entry at FIFO head
out_ready_i  in  1  EX accepts head
pc_o  out  PC_W  PC of head
inst_type_o  out  4  op-class code
rd_o/rs1_o/rs2_o  out  5 each  register indices
imm_o  out  XLEN  sign-extended immediate (0 for R-type)
is_load_o, is_store_o, is_branch_o, is_jal_o, is_jalr_o  out  1 each  class flags
is_U_o  out  1  unsigned variant (sltu/sltiu/bltu/bgeu/mulhu/divu/remu)
is_W_o  out  1  32-bit W-op (OP-32/OP-IMM-32)
is_mul_o, is_div_o, is_rem_o  out  1 each  M-ext class
illegal_o  out  1  unrecognised encoding
explicit_type_o  out  TYPE_W  one-hot ALU op

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst. Reset clears the FIFO: out_valid_o=0 and all payload outputs read 0. in_ready_o=0 while rst=1, and 1 in the first cycle after it.
- Push occurs when in_valid_i & in_ready_o & !flush_i; pop occurs when out_valid_o & out_ready_i.
- in_ready_o = (count < BUF_DEPTH). There is no combinational pass-through: a same-cycle pop does not raise in_ready_o when the FIFO is full.
- Latency: an accepted beat appears at the head one cycle later if the FIFO was empty.
- Simultaneous push and pop: count is unchanged and pointers wrap modulo BUF_DEPTH.
- out_valid_o = (count != 0). The head payload holds stable while out_valid_o=1 and out_ready_i=0.
- flush_i: count and pointers go to 0 on the next edge. A same-cycle push is dropped and a same-cycle pop is ignored. flush_i has lower priority than rst.
- Decode is combinational on inst_i and registered into the FIFO.
  - Immediate generation follows RV I/S/B/U/J formats, sign-extended to XLEN.
  - AUIPC maps to ADD.
  - Shift immediates use inst[25:20] for RV64; W-shifts require inst[25]=0.
- explicit_type bit map: 0 ADD, 1 AND, 2 SUB, 3 OR, 4 XOR, 5 SLT, 6 SLL, 7 SRL, 8 SRA, 9 BEQ, 10 BNE, 11 BLT, 12 BGE, 13 MUL, 14 DIV, 15 REM. Bits above 15 are 0.
  - BLTU/BGEU set bit 11/12 with is_U.
  - MULH* sets bit 13. Only MULHU sets is_U; MULHSU is left for EX to handle via funct3.
- Loads, stores, JAL, JALR, LUI and SYSTEM carry explicit_type = 0, except: load/store/JALR set bit 0 (address add).
- Illegal encoding:
  - Conditions: unknown opcode; an R-type funct7 outside {0000000, 0100000 for SUB/SRA/SUBW/SRAW}; bad funct3 for B/load/store.
  - Result: illegal_o=1, all other flags 0, explicit_type 0. The entry is still pushed.

Optional Feature:
RV_M_EXT_EN
- Defined: funct7=0000001 on OP/OP-32 decodes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU and their W forms. It sets is_mul/is_div/is_rem, bits 13–15 and is_U as specified.
- Undefined: those encodings set illegal_o=1; is_mul/is_div/is_rem tie to 0 and bits 13–15 are always 0.

Decomposition:
- The shared INST_TYPE include holds:
  - the 4-bit op-class codes: INST_R_, INST_I_, INST_I_LOAD, INST_S_, INST_B_, INST_J_JAL, INST_I_JALR, INST_U_LUI, INST_U_AUIPC, INST_R_W, INST_I_W, INST_SYS, INST_ILL;
  - the 7-bit opcode constants;
  - EXPLICIT_TYPE_NUM and the explicit-type bit indices.
- One sub-module, ysyx_22051468_decode_comb: the pure combinational decoder. The top holds the FIFO, handshake and flush.

Test Plan:
1. addi x1,x0,5 (0x00500093), PC 0x80000000, out_ready=1 -> next cycle out_valid=1, rd=1, rs1=0, imm=5, explicit_type=bit0, illegal=0.
2. sub x3,x1,x2 (0x402081B3) then bltu x1,x2,+8 (0x0020E463) back-to-back -> bit2 entry first; then bit11, is_U=1, is_branch=1, imm=8.
3. Hold out_ready=0, push 3 beats with BUF_DEPTH=2 -> in_ready drops after 2 pushes and head stays 1st beat. Release -> order preserved, no loss or duplication.
4. mul x5,x6,x7 (0x027302B3) -> with RV_M_EXT_EN: is_mul=1, bit13. Without it: illegal=1, explicit_type=0.
5. addiw x1,x1,-1 (0xFFF0809B) -> is_W=1, bit0, imm=0xFFFF_FFFF_FFFF_FFFF. Then 0x0000007F -> illegal=1.
6. FIFO full, assert flush_i with in_valid=1 -> next cycle out_valid=0, in_ready=1, the flushed beat never appears. Assert rst mid-stream -> same, with all outputs 0.

Source files
------------

// File: rtl/ysyx_22051468_decode_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22051468_decode_stage_pkg
// Description : Shared INST_TYPE definitions for the RV64 decode stage.
//               Holds the op-class codes, the major opcodes, the one-hot
//               explicit-type bit indices and a base-ALU funct3 helper.
// Revision    : 1.0 - initial release
// ============================================================================
package ysyx_22051468_decode_stage_pkg;

    // 4-bit op-class codes
    localparam logic [3:0] INST_R_      = 4'd0;
    localparam logic [3:0] INST_I_      = 4'd1;
    localparam logic [3:0] INST_I_LOAD  = 4'd2;
    localparam logic [3:0] INST_S_      = 4'd3;
    localparam logic [3:0] INST_B_      = 4'd4;
    localparam logic [3:0] INST_J_JAL   = 4'd5;
    localparam logic [3:0] INST_I_JALR  = 4'd6;
    localparam logic [3:0] INST_U_LUI   = 4'd7;
    localparam logic [3:0] INST_U_AUIPC = 4'd8;
    localparam logic [3:0] INST_R_W     = 4'd9;
    localparam logic [3:0] INST_I_W     = 4'd10;
    localparam logic [3:0] INST_SYS     = 4'd11;
    localparam logic [3:0] INST_ILL     = 4'd12;

    // 7-bit major opcodes
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    // Explicit-type one-hot bit indices
    localparam int EXPLICIT_TYPE_NUM = 16;
    localparam int ET_ADD = 0;
    localparam int ET_AND = 1;
    localparam int ET_SUB = 2;
    localparam int ET_OR  = 3;
    localparam int ET_XOR = 4;
    localparam int ET_SLT = 5;
    localparam int ET_SLL = 6;
    localparam int ET_SRL = 7;
    localparam int ET_SRA = 8;
    localparam int ET_BEQ = 9;
    localparam int ET_BNE = 10;
    localparam int ET_BLT = 11;
    localparam int ET_BGE = 12;
    localparam int ET_MUL = 13;
    localparam int ET_DIV = 14;
    localparam int ET_REM = 15;

    // One-hot ALU op for the funct3 field of OP / OP-IMM with funct7=0
    function automatic logic [EXPLICIT_TYPE_NUM-1:0] alu_base_onehot(input logic [2:0] funct3);
        logic [EXPLICIT_TYPE_NUM-1:0] v;
        v = '0;
        case (funct3)
            3'b000:  v[ET_ADD] = 1'b1;
            3'b001:  v[ET_SLL] = 1'b1;
            3'b010:  v[ET_SLT] = 1'b1;
            3'b011:  v[ET_SLT] = 1'b1;
            3'b100:  v[ET_XOR] = 1'b1;
            3'b101:  v[ET_SRL] = 1'b1;
            3'b110:  v[ET_OR]  = 1'b1;
            default: v[ET_AND] = 1'b1;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_22051468_decode_comb.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22051468_decode_comb
// Description : Pure combinational RV64I(+M) instruction decoder.
//               Optional macro RV_M_EXT_EN enables M-extension decode;
//               without it funct7=0000001 on OP/OP-32 decodes as illegal.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22051468_decode_comb
    import ysyx_22051468_decode_stage_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int TYPE_W = 16
) (
    input  logic [31:0]       i_inst,
    output logic [3:0]        o_inst_type,
    output logic [4:0]        o_rd,
    output logic [4:0]        o_rs1,
    output logic [4:0]        o_rs2,
    output logic [XLEN-1:0]   o_imm,
    output logic [10:0]       o_flags,   // {load,store,branch,jal,jalr,U,W,mul,div,rem,illegal}
    output logic [TYPE_W-1:0] o_explicit_type
);

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_imm_sh;

    assign w_opcode = i_inst[6:0];
    assign w_funct3 = i_inst[14:12];
    assign w_funct7 = i_inst[31:25];
    assign o_rd     = i_inst[11:7];
    assign o_rs1    = i_inst[19:15];
    assign o_rs2    = i_inst[24:20];

    assign w_imm_i  = {{(XLEN-12){i_inst[31]}}, i_inst[31:20]};
    assign w_imm_s  = {{(XLEN-12){i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
    assign w_imm_b  = {{(XLEN-13){i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
    assign w_imm_u  = {{(XLEN-32){i_inst[31]}}, i_inst[31:12], 12'b0};
    assign w_imm_j  = {{(XLEN-21){i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
    // RV64 shift amounts are 6 bits wide, zero-extended
    assign w_imm_sh = {{(XLEN-6){1'b0}}, i_inst[25:20]};

    logic [3:0]                   w_type;
    logic [XLEN-1:0]              w_imm;
    logic [EXPLICIT_TYPE_NUM-1:0] w_et;
    logic w_load, w_store, w_branch, w_jal, w_jalr, w_u, w_w, w_mul, w_div, w_rem, w_ill;

    // Decode opcode/funct fields into class, immediate, flags and ALU op
    always_comb begin
        w_type   = INST_ILL;
        w_imm    = '0;
        w_et     = '0;
        w_load   = 1'b0;
        w_store  = 1'b0;
        w_branch = 1'b0;
        w_jal    = 1'b0;
        w_jalr   = 1'b0;
        w_u      = 1'b0;
        w_w      = 1'b0;
        w_mul    = 1'b0;
        w_div    = 1'b0;
        w_rem    = 1'b0;
        w_ill    = 1'b0;
        case (w_opcode)
            OPC_LUI: begin
                w_type = INST_U_LUI;
                w_imm  = w_imm_u;
            end
            OPC_AUIPC: begin
                w_type       = INST_U_AUIPC;
                w_imm        = w_imm_u;
                w_et[ET_ADD] = 1'b1;
            end
            OPC_JAL: begin
                w_type = INST_J_JAL;
                w_imm  = w_imm_j;
                w_jal  = 1'b1;
            end
            OPC_JALR: begin
                w_type       = INST_I_JALR;
                w_imm        = w_imm_i;
                w_jalr       = 1'b1;
                w_et[ET_ADD] = 1'b1;
            end
            OPC_BRANCH: begin
                w_type   = INST_B_;
                w_imm    = w_imm_b;
                w_branch = 1'b1;
                case (w_funct3)
                    3'b000:  w_et[ET_BEQ] = 1'b1;
                    3'b001:  w_et[ET_BNE] = 1'b1;
                    3'b100:  w_et[ET_BLT] = 1'b1;
                    3'b101:  w_et[ET_BGE] = 1'b1;
                    3'b110:  begin w_et[ET_BLT] = 1'b1; w_u = 1'b1; end
                    3'b111:  begin w_et[ET_BGE] = 1'b1; w_u = 1'b1; end
                    default: w_ill = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                w_type       = INST_I_LOAD;
                w_imm        = w_imm_i;
                w_load       = 1'b1;
                w_et[ET_ADD] = 1'b1;
                w_ill        = (w_funct3 == 3'b111);
            end
            OPC_STORE: begin
                w_type       = INST_S_;
                w_imm        = w_imm_s;
                w_store      = 1'b1;
                w_et[ET_ADD] = 1'b1;
                w_ill        = w_funct3[2];
            end
            OPC_OP_IMM: begin
                w_type = INST_I_;
                w_imm  = w_imm_i;
                w_et   = alu_base_onehot(w_funct3);
                w_u    = (w_funct3 == 3'b011);
                if (w_funct3 == 3'b001) begin
                    w_imm = w_imm_sh;
                    w_ill = (i_inst[31:26] != 6'b000000);
                end else if (w_funct3 == 3'b101) begin
                    w_imm = w_imm_sh;
                    if (i_inst[31:26] == 6'b010000) begin
                        w_et         = '0;
                        w_et[ET_SRA] = 1'b1;
                    end else begin
                        w_ill = (i_inst[31:26] != 6'b000000);
                    end
                end
            end
            OPC_OP_IMM_32: begin
                w_type = INST_I_W;
                w_w    = 1'b1;
                w_imm  = w_imm_i;
                case (w_funct3)
                    3'b000: w_et[ET_ADD] = 1'b1;
                    3'b001: begin
                        w_imm        = w_imm_sh;
                        w_et[ET_SLL] = 1'b1;
                        w_ill        = (w_funct7 != 7'b0000000);
                    end
                    3'b101: begin
                        w_imm = w_imm_sh;
                        if (w_funct7 == 7'b0000000)      w_et[ET_SRL] = 1'b1;
                        else if (w_funct7 == 7'b0100000) w_et[ET_SRA] = 1'b1;
                        else                             w_ill = 1'b1;
                    end
                    default: w_ill = 1'b1;
                endcase
            end
            OPC_OP: begin
                w_type = INST_R_;
                case (w_funct7)
                    7'b0000000: begin
                        w_et = alu_base_onehot(w_funct3);
                        w_u  = (w_funct3 == 3'b011);
                    end
                    7'b0100000: begin
                        if (w_funct3 == 3'b000)      w_et[ET_SUB] = 1'b1;
                        else if (w_funct3 == 3'b101) w_et[ET_SRA] = 1'b1;
                        else                         w_ill = 1'b1;
                    end
`ifdef RV_M_EXT_EN
                    7'b0000001: begin
                        case (w_funct3[2:1])
                            2'b00, 2'b01: begin w_mul = 1'b1; w_et[ET_MUL] = 1'b1; end
                            2'b10:        begin w_div = 1'b1; w_et[ET_DIV] = 1'b1; end
                            default:      begin w_rem = 1'b1; w_et[ET_REM] = 1'b1; end
                        endcase
                        // mulhu / divu / remu; mulhsu stays signed here
                        w_u = (w_funct3 == 3'b011) || (w_funct3 == 3'b101) || (w_funct3 == 3'b111);
                    end
`endif
                    default: w_ill = 1'b1;
                endcase
            end
            OPC_OP_32: begin
                w_type = INST_R_W;
                w_w    = 1'b1;
                case (w_funct7)
                    7'b0000000: begin
                        case (w_funct3)
                            3'b000:  w_et[ET_ADD] = 1'b1;
                            3'b001:  w_et[ET_SLL] = 1'b1;
                            3'b101:  w_et[ET_SRL] = 1'b1;
                            default: w_ill = 1'b1;
                        endcase
                    end
                    7'b0100000: begin
                        if (w_funct3 == 3'b000)      w_et[ET_SUB] = 1'b1;
                        else if (w_funct3 == 3'b101) w_et[ET_SRA] = 1'b1;
                        else                         w_ill = 1'b1;
                    end
`ifdef RV_M_EXT_EN
                    7'b0000001: begin
                        case (w_funct3)
                            3'b000:  begin w_mul = 1'b1; w_et[ET_MUL] = 1'b1; end
                            3'b100:  begin w_div = 1'b1; w_et[ET_DIV] = 1'b1; end
                            3'b101:  begin w_div = 1'b1; w_et[ET_DIV] = 1'b1; w_u = 1'b1; end
                            3'b110:  begin w_rem = 1'b1; w_et[ET_REM] = 1'b1; end
                            3'b111:  begin w_rem = 1'b1; w_et[ET_REM] = 1'b1; w_u = 1'b1; end
                            default: w_ill = 1'b1;
                        endcase
                    end
`endif
                    default: w_ill = 1'b1;
                endcase
            end
            OPC_SYSTEM: begin
                w_type = INST_SYS;
                w_imm  = w_imm_i;
            end
            default: w_ill = 1'b1;
        endcase

        // Illegal encodings carry only the illegal flag downstream
        if (w_ill) begin
            w_type   = INST_ILL;
            w_imm    = '0;
            w_et     = '0;
            w_load   = 1'b0;
            w_store  = 1'b0;
            w_branch = 1'b0;
            w_jal    = 1'b0;
            w_jalr   = 1'b0;
            w_u      = 1'b0;
            w_w      = 1'b0;
            w_mul    = 1'b0;
            w_div    = 1'b0;
            w_rem    = 1'b0;
        end
    end

    assign o_inst_type     = w_type;
    assign o_imm           = w_imm;
    assign o_flags         = {w_load, w_store, w_branch, w_jal, w_jalr, w_u, w_w, w_mul, w_div, w_rem, w_ill};
    assign o_explicit_type = TYPE_W'(w_et);

endmodule
`default_nettype wire

// File: rtl/ysyx_22051468_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22051468_decode_stage
// Description : Registered RV64 decode stage with valid/ready handshake,
//               a BUF_DEPTH-entry output FIFO and flush. Optional macro
//               RV_M_EXT_EN (in the decoder) enables M-extension decode.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22051468_decode_stage
    import ysyx_22051468_decode_stage_pkg::*;
#(
    parameter int XLEN      = 64,
    parameter int PC_W      = 64,
    parameter int TYPE_W    = 16,
    parameter int BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [31:0]       inst_i,
    input  logic [PC_W-1:0]   pc_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [PC_W-1:0]   pc_o,
    output logic [3:0]        inst_type_o,
    output logic [4:0]        rd_o,
    output logic [4:0]        rs1_o,
    output logic [4:0]        rs2_o,
    output logic [XLEN-1:0]   imm_o,
    output logic              is_load_o,
    output logic              is_store_o,
    output logic              is_branch_o,
    output logic              is_jal_o,
    output logic              is_jalr_o,
    output logic              is_U_o,
    output logic              is_W_o,
    output logic              is_mul_o,
    output logic              is_div_o,
    output logic              is_rem_o,
    output logic              illegal_o,
    output logic [TYPE_W-1:0] explicit_type_o
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int PAY_W = PC_W + 4 + 15 + XLEN + 11 + TYPE_W;

    logic [3:0]        w_inst_type;
    logic [4:0]        w_rd, w_rs1, w_rs2;
    logic [XLEN-1:0]   w_imm;
    logic [10:0]       w_flags;
    logic [TYPE_W-1:0] w_et;

    ysyx_22051468_decode_comb #(
        .XLEN   (XLEN),
        .TYPE_W (TYPE_W)
    ) u_decode_comb (
        .i_inst          (inst_i),
        .o_inst_type     (w_inst_type),
        .o_rd            (w_rd),
        .o_rs1           (w_rs1),
        .o_rs2           (w_rs2),
        .o_imm           (w_imm),
        .o_flags         (w_flags),
        .o_explicit_type (w_et)
    );

    logic [PAY_W-1:0] r_mem [BUF_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push, w_pop;
    logic [PAY_W-1:0] w_wr_data, w_head;

    // No pass-through: readiness depends only on stored occupancy
    assign in_ready_o  = !rst && (r_count < CNT_W'(BUF_DEPTH));
    assign out_valid_o = (r_count != '0);
    assign w_push      = in_valid_i && in_ready_o && !flush_i;
    assign w_pop       = out_valid_o && out_ready_i;
    assign w_wr_data   = {pc_i, w_inst_type, w_rd, w_rs1, w_rs2, w_imm, w_flags, w_et};

    // FIFO storage, pointers and occupancy; flush empties, reset also clears payload
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_wr_data;
                r_wr_ptr <= (r_wr_ptr == PTR_W'(BUF_DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_W'(BUF_DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    assign w_head = r_mem[r_rd_ptr];
    assign {pc_o, inst_type_o, rd_o, rs1_o, rs2_o, imm_o,
            is_load_o, is_store_o, is_branch_o, is_jal_o, is_jalr_o,
            is_U_o, is_W_o, is_mul_o, is_div_o, is_rem_o, illegal_o,
            explicit_type_o} = w_head;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22051468_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_22051468_decode_stage
// Description : Directed self-checking bench for the RV64 decode stage.
//               Honours RV_M_EXT_EN for the M-extension expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_22051468_decode_stage;
    import ysyx_22051468_decode_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush_i = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [31:0] inst_i = '0;
    logic [63:0] pc_i = '0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [63:0] pc_o;
    logic [3:0]  inst_type_o;
    logic [4:0]  rd_o, rs1_o, rs2_o;
    logic [63:0] imm_o;
    logic        is_load_o, is_store_o, is_branch_o, is_jal_o, is_jalr_o;
    logic        is_U_o, is_W_o, is_mul_o, is_div_o, is_rem_o, illegal_o;
    logic [15:0] explicit_type_o;
    logic [10:0] flags;

    int n_checks = 0;
    int n_fail   = 0;

    ysyx_22051468_decode_stage #(
        .XLEN(64), .PC_W(64), .TYPE_W(16), .BUF_DEPTH(2)
    ) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .inst_i(inst_i), .pc_i(pc_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .pc_o(pc_o), .inst_type_o(inst_type_o),
        .rd_o(rd_o), .rs1_o(rs1_o), .rs2_o(rs2_o), .imm_o(imm_o),
        .is_load_o(is_load_o), .is_store_o(is_store_o), .is_branch_o(is_branch_o),
        .is_jal_o(is_jal_o), .is_jalr_o(is_jalr_o), .is_U_o(is_U_o), .is_W_o(is_W_o),
        .is_mul_o(is_mul_o), .is_div_o(is_div_o), .is_rem_o(is_rem_o),
        .illegal_o(illegal_o), .explicit_type_o(explicit_type_o)
    );

    always #5 clk = ~clk;

    // {load,store,branch,jal,jalr,U,W,mul,div,rem,illegal}
    assign flags = {is_load_o, is_store_o, is_branch_o, is_jal_o, is_jalr_o,
                    is_U_o, is_W_o, is_mul_o, is_div_o, is_rem_o, illegal_o};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        n_checks++;
        if ({in_ready_o, out_valid_o} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_hold: ready/valid=%b expected 00", {in_ready_o, out_valid_o});
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b expected 1", in_ready_o);
        end
        n_checks++;
        if ({pc_o, imm_o, explicit_type_o, flags, rd_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_payload: pc=%h imm=%h et=%h flags=%h expected all zero",
                     pc_o, imm_o, explicit_type_o, flags);
        end
    endtask

    task automatic test_addi();
        out_ready_i = 1'b1;
        in_valid_i  = 1'b1;
        inst_i      = 32'h0050_0093;
        pc_i        = 64'h8000_0000;
        step();
        in_valid_i = 1'b0;
        n_checks++;
        if ({out_valid_o, pc_o, rd_o, rs1_o, imm_o} !== {1'b1, 64'h8000_0000, 5'd1, 5'd0, 64'd5}) begin
            n_fail++;
            $display("FAIL addi_fields: valid=%b pc=%h rd=%0d rs1=%0d imm=%h expected 1/80000000/1/0/5",
                     out_valid_o, pc_o, rd_o, rs1_o, imm_o);
        end
        n_checks++;
        if ({inst_type_o, explicit_type_o, flags} !== {INST_I_, 16'h0001, 11'h000}) begin
            n_fail++;
            $display("FAIL addi_type: type=%h et=%h flags=%h expected 1/0001/000",
                     inst_type_o, explicit_type_o, flags);
        end
        step();
        n_checks++;
        if (out_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL addi_pop: valid=%b expected 0", out_valid_o);
        end
    endtask

    task automatic test_back_to_back();
        out_ready_i = 1'b1;
        in_valid_i  = 1'b1;
        inst_i      = 32'h4020_81B3;
        pc_i        = 64'h8000_0010;
        step();
        inst_i = 32'h0020_E463;
        pc_i   = 64'h8000_0014;
        n_checks++;
        if ({pc_o, rd_o, rs1_o, rs2_o, explicit_type_o, inst_type_o, flags} !==
            {64'h8000_0010, 5'd3, 5'd1, 5'd2, 16'h0004, INST_R_, 11'h000}) begin
            n_fail++;
            $display("FAIL sub_entry: pc=%h rd=%0d rs1=%0d rs2=%0d et=%h type=%h flags=%h",
                     pc_o, rd_o, rs1_o, rs2_o, explicit_type_o, inst_type_o, flags);
        end
        step();
        in_valid_i = 1'b0;
        n_checks++;
        if ({out_valid_o, pc_o, explicit_type_o, flags, imm_o, inst_type_o} !==
            {1'b1, 64'h8000_0014, 16'h0800, 11'h120, 64'd8, INST_B_}) begin
            n_fail++;
            $display("FAIL bltu_entry: valid=%b pc=%h et=%h flags=%h imm=%h type=%h expected 1/80000014/0800/120/8/4",
                     out_valid_o, pc_o, explicit_type_o, flags, imm_o, inst_type_o);
        end
        step();
        n_checks++;
        if (out_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_drain: valid=%b expected 0", out_valid_o);
        end
    endtask

    task automatic test_backpressure();
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        inst_i      = 32'h0050_0093;
        pc_i        = 64'h100;
        step();
        n_checks++;
        if ({in_ready_o, out_valid_o, pc_o} !== {1'b1, 1'b1, 64'h100}) begin
            n_fail++;
            $display("FAIL bp_first: ready=%b valid=%b pc=%h expected 1/1/100", in_ready_o, out_valid_o, pc_o);
        end
        pc_i = 64'h104;
        step();
        pc_i = 64'h108;
        n_checks++;
        if ({in_ready_o, pc_o} !== {1'b0, 64'h100}) begin
            n_fail++;
            $display("FAIL bp_full: ready=%b pc=%h expected 0/100", in_ready_o, pc_o);
        end
        step();
        n_checks++;
        if ({in_ready_o, out_valid_o, pc_o} !== {1'b0, 1'b1, 64'h100}) begin
            n_fail++;
            $display("FAIL bp_hold: ready=%b valid=%b pc=%h expected 0/1/100", in_ready_o, out_valid_o, pc_o);
        end
        out_ready_i = 1'b1;
        step();
        n_checks++;
        if ({in_ready_o, pc_o} !== {1'b1, 64'h104}) begin
            n_fail++;
            $display("FAIL bp_release1: ready=%b pc=%h expected 1/104", in_ready_o, pc_o);
        end
        step();
        in_valid_i = 1'b0;
        n_checks++;
        if ({out_valid_o, pc_o} !== {1'b1, 64'h108}) begin
            n_fail++;
            $display("FAIL bp_release2: valid=%b pc=%h expected 1/108", out_valid_o, pc_o);
        end
        step();
        n_checks++;
        if (out_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_drain: valid=%b expected 0 (duplicate entry)", out_valid_o);
        end
    endtask

    task automatic test_mext();
        logic [15:0] exp_et;
        logic [10:0] exp_flags;
`ifdef RV_M_EXT_EN
        exp_et    = 16'h2000;
        exp_flags = 11'h008;
`else
        exp_et    = 16'h0000;
        exp_flags = 11'h001;
`endif
        out_ready_i = 1'b1;
        in_valid_i  = 1'b1;
        inst_i      = 32'h0273_02B3;
        pc_i        = 64'h200;
        step();
        in_valid_i = 1'b0;
        n_checks++;
        if ({out_valid_o, explicit_type_o, flags} !== {1'b1, exp_et, exp_flags}) begin
            n_fail++;
            $display("FAIL mul_decode: valid=%b et=%h flags=%h expected 1/%h/%h",
                     out_valid_o, explicit_type_o, flags, exp_et, exp_flags);
        end
        step();
    endtask

    task automatic test_w_and_illegal();
        out_ready_i = 1'b1;
        in_valid_i  = 1'b1;
        inst_i      = 32'hFFF0_809B;
        pc_i        = 64'h300;
        step();
        inst_i = 32'h0000_007F;
        pc_i   = 64'h304;
        n_checks++;
        if ({imm_o, explicit_type_o, flags, inst_type_o, rd_o, rs1_o} !==
            {64'hFFFF_FFFF_FFFF_FFFF, 16'h0001, 11'h010, INST_I_W, 5'd1, 5'd1}) begin
            n_fail++;
            $display("FAIL addiw: imm=%h et=%h flags=%h type=%h expected ffffffffffffffff/0001/010/a",
                     imm_o, explicit_type_o, flags, inst_type_o);
        end
        step();
        in_valid_i = 1'b0;
        n_checks++;
        if ({out_valid_o, pc_o, explicit_type_o, flags, inst_type_o} !==
            {1'b1, 64'h304, 16'h0000, 11'h001, INST_ILL}) begin
            n_fail++;
            $display("FAIL illegal_opcode: valid=%b pc=%h et=%h flags=%h type=%h expected 1/304/0000/001/c",
                     out_valid_o, pc_o, explicit_type_o, flags, inst_type_o);
        end
        step();
    endtask

    task automatic test_flush();
        // Flush with an empty FIFO drops the concurrent beat
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        inst_i      = 32'h0050_0093;
        pc_i        = 64'h400;
        flush_i     = 1'b1;
        step();
        flush_i = 1'b0;
        in_valid_i = 1'b0;
        n_checks++;
        if (out_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_empty_push: valid=%b expected 0", out_valid_o);
        end
        // Fill, then flush while a new beat is offered
        in_valid_i = 1'b1;
        pc_i = 64'h410;
        step();
        pc_i = 64'h414;
        step();
        pc_i    = 64'h418;
        flush_i = 1'b1;
        step();
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        n_checks++;
        if ({out_valid_o, in_ready_o} !== 2'b01) begin
            n_fail++;
            $display("FAIL flush_full: valid/ready=%b expected 01", {out_valid_o, in_ready_o});
        end
        out_ready_i = 1'b1;
        step();
        n_checks++;
        if (out_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_leak: valid=%b pc=%h expected valid 0", out_valid_o, pc_o);
        end
    endtask

    task automatic test_rst_mid();
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        inst_i      = 32'h0020_E463;
        pc_i        = 64'h500;
        step();
        pc_i = 64'h504;
        step();
        in_valid_i = 1'b0;
        rst = 1'b1;
        step();
        n_checks++;
        if ({in_ready_o, out_valid_o} !== 2'b00) begin
            n_fail++;
            $display("FAIL rst_mid_hold: ready/valid=%b expected 00", {in_ready_o, out_valid_o});
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if ({in_ready_o, out_valid_o, pc_o, imm_o, explicit_type_o, flags, inst_type_o} !==
            {1'b1, 1'b0, 64'h0, 64'h0, 16'h0, 11'h0, 4'h0}) begin
            n_fail++;
            $display("FAIL rst_mid_clear: ready=%b valid=%b pc=%h imm=%h et=%h flags=%h expected 1/0/all zero",
                     in_ready_o, out_valid_o, pc_o, imm_o, explicit_type_o, flags);
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_back_to_back();
        test_backpressure();
        test_mext();
        test_w_and_illegal();
        test_flush();
        test_rst_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
